// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that feeds one uart_tx from two byte requesters.
// A watchdog abandons any transmission that uart_tx never finishes.
module uart_tx_arbiter #(
   parameter int TO_W    = 20,
   parameter int TIMEOUT = 200000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic       req0,
   input  logic [7:0] data0,
   input  logic       req1,
   input  logic [7:0] data1,
   output logic       gnt0,
   output logic       gnt1,
   output logic       done0,
   output logic       done1,
   output logic       err,
   output logic       owner,
   output logic       busy,
   output logic       start_tx,
   output logic [7:0] data_out,
   input  logic       tx_busy,
   input  logic       tx_done
);
   typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, WAIT_DONE} state_t;

   // A wait cycle that begins with this count ends with the counter at TIMEOUT-1,
   // so the abort decision is made then unless tx_done arrives in the same cycle.
   localparam logic [TO_W-1:0] WDOG_LAST = TO_W'(TIMEOUT - 2);
   localparam logic [TO_W-1:0] WDOG_MAX  = '1;

   state_t          state_reg, state_next;
   logic            last_served_reg, last_served_next;
   logic [TO_W-1:0] wdog_reg, wdog_next;
   logic [1:0]      gnt_reg, gnt_next;
   logic [1:0]      done_reg, done_next;
   logic            err_reg, err_next;
   logic            owner_reg, owner_next;
   logic            busy_reg, busy_next;
   logic            start_reg, start_next;
   logic [7:0]      data_reg, data_next;
   logic            winner;

   // last_served only breaks ties; a lone requester wins outright.
   assign winner = (req0 && req1) ? ~last_served_reg : req1;

   always_comb begin
      state_next       = state_reg;
      last_served_next = last_served_reg;
      wdog_next        = wdog_reg;
      owner_next       = owner_reg;
      data_next        = data_reg;
      gnt_next         = 2'b00;
      done_next        = 2'b00;
      err_next         = 1'b0;
      start_next       = 1'b0;
      busy_next        = 1'b0;
      case (state_reg)
         IDLE: begin
            if (en && (req0 || req1)) begin
               state_next       = START;
               owner_next       = winner;
               data_next        = winner ? data1 : data0;
               last_served_next = winner;
               gnt_next         = winner ? 2'b10 : 2'b01;
               start_next       = 1'b1;
            end
         end
         START: begin
            state_next = WAIT_BUSY;
            wdog_next  = '0;
         end
         WAIT_BUSY, WAIT_DONE: begin
            if (wdog_reg != WDOG_MAX) begin
               wdog_next = wdog_reg + 1'b1;
            end
            if (tx_done) begin
               state_next = IDLE;
               done_next  = owner_reg ? 2'b10 : 2'b01;
            end else if (wdog_reg >= WDOG_LAST) begin
               state_next = IDLE;
               err_next   = 1'b1;
            end else if (state_reg == WAIT_BUSY && tx_busy) begin
               state_next = WAIT_DONE;
            end
         end
         default: state_next = IDLE;
      endcase
      busy_next = (state_next != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg       <= IDLE;
         last_served_reg <= 1'b1;
         wdog_reg        <= '0;
         gnt_reg         <= 2'b00;
         done_reg        <= 2'b00;
         err_reg         <= 1'b0;
         owner_reg       <= 1'b0;
         busy_reg        <= 1'b0;
         start_reg       <= 1'b0;
         data_reg        <= 8'h00;
      end else begin
         state_reg       <= state_next;
         last_served_reg <= last_served_next;
         wdog_reg        <= wdog_next;
         gnt_reg         <= gnt_next;
         done_reg        <= done_next;
         err_reg         <= err_next;
         owner_reg       <= owner_next;
         busy_reg        <= busy_next;
         start_reg       <= start_next;
         data_reg        <= data_next;
      end
   end

   assign gnt0     = gnt_reg[0];
   assign gnt1     = gnt_reg[1];
   assign done0    = done_reg[0];
   assign done1    = done_reg[1];
   assign err      = err_reg;
   assign owner    = owner_reg;
   assign busy     = busy_reg;
   assign start_tx = start_reg;
   assign data_out = data_reg;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboarded bench for uart_tx_arbiter driven against a behavioural uart_tx model.
// Event kinds: 0 gnt0, 1 gnt1, 2 done0, 3 done1, 4 err.
module tb_uart_tx_arbiter;
   localparam int TMO = 16;

   logic       clk = 1'b0;
   logic       rst, en, req0, req1, tx_busy, tx_done;
   logic [7:0] data0, data1, data_out;
   logic       gnt0, gnt1, done0, done1, err, owner, busy, start_tx;
   logic [4:0] pulses;

   typedef struct {
      int         kind;
      int         at;
      logic [7:0] dat;
   } exp_t;

   typedef struct {
      bit         r0;
      bit         r1;
      logic [7:0] d0;
      logic [7:0] d1;
      int         n;
      bit         win;
      logic [7:0] dat;
   } vec_t;

   exp_t sb[$];
   vec_t tbl[10];
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   model_n = 0;
   int   next_free = 0;
   int   s, s_last, g;

   uart_tx_arbiter #(.TO_W(8), .TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst), .en(en),
      .req0(req0), .data0(data0), .req1(req1), .data1(data1),
      .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1), .err(err),
      .owner(owner), .busy(busy), .start_tx(start_tx), .data_out(data_out),
      .tx_busy(tx_busy), .tx_done(tx_done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   assign pulses = {err, done1, done0, gnt1, gnt0};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
      end
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_data_out"}, data_out, 32'h00);
      check({tag, "_owner"}, owner, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_start_tx"}, start_tx, 0);
      check({tag, "_pulses"}, pulses, 0);
   endtask

   task automatic push_evt(input int kind, input int at, input logic [7:0] dat);
      exp_t e;
      e.kind = kind;
      e.at   = at;
      e.dat  = dat;
      sb.push_back(e);
   endtask

   // Grant at cycle st; uart_tx pulses tx_done at st+n (n=0: never).
   task automatic push_txn(input int st, input bit win, input logic [7:0] dat, input int n);
      push_evt(int'(win), st, dat);
      if (n >= 1 && n <= TMO - 1) next_free = st + n + 1;
      else                        next_free = st + TMO;
      push_evt((n >= 1 && n <= TMO - 1) ? 2 + int'(win) : 4, next_free, 8'h00);
   endtask

   // uart_tx model: busy from start+2, tx_done at start+model_n.
   initial begin
      tx_busy = 1'b0;
      tx_done = 1'b0;
      forever begin
         @(negedge clk);
         tx_busy = 1'b0;
         tx_done = 1'b0;
         if (start_tx) begin
            int n;
            n = model_n;
            for (int k = 1; k <= n; k++) begin
               @(negedge clk);
               tx_busy = (k >= 2 && k < n);
               tx_done = (k == n);
            end
         end
      end
   end

   // Output monitor: every strobe must match the head of the scoreboard.
   initial begin
      forever begin
         @(negedge clk);
         if (start_tx) check("start_has_gnt", gnt0 | gnt1, 1);
         if (pulses != 5'b0) begin
            int   act;
            exp_t e;
            act = 0;
            for (int b = 4; b >= 0; b--) if (pulses[b]) act = b;
            check("pulse_onehot", $countones(pulses), 1);
            check("event_expected", (sb.size() > 0) ? 1 : 0, 1);
            if (sb.size() > 0) begin
               e = sb.pop_front();
               check("event_kind", act, e.kind);
               check("event_cycle", cyc, e.at);
               if (e.kind < 2) begin
                  check("gnt_data_out", data_out, e.dat);
                  check("gnt_owner", owner, e.kind);
                  check("gnt_busy", busy, 1);
               end else begin
                  check("end_busy", busy, 0);
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL time_limit: simulation exceeded its cycle budget");
      $fatal(1, "time limit");
   end

   initial begin
      tbl[0] = '{1'b1, 1'b0, 8'hA5, 8'h00,  4, 1'b0, 8'hA5};
      tbl[1] = '{1'b0, 1'b1, 8'hA5, 8'h3C,  5, 1'b1, 8'h3C};
      tbl[2] = '{1'b1, 1'b1, 8'h11, 8'h22,  3, 1'b0, 8'h11};
      tbl[3] = '{1'b1, 1'b1, 8'h44, 8'h22,  2, 1'b1, 8'h22};
      tbl[4] = '{1'b1, 1'b0, 8'h44, 8'h22,  1, 1'b0, 8'h44};
      tbl[5] = '{1'b1, 1'b0, 8'h00, 8'h22, 15, 1'b0, 8'h00};
      tbl[6] = '{1'b0, 1'b1, 8'h00, 8'hFF,  0, 1'b1, 8'hFF};
      tbl[7] = '{1'b1, 1'b1, 8'h81, 8'h18, 16, 1'b0, 8'h81};
      tbl[8] = '{1'b1, 1'b1, 8'h7E, 8'h18,  2, 1'b1, 8'h18};
      tbl[9] = '{1'b1, 1'b0, 8'h7E, 8'h18,  6, 1'b0, 8'h7E};

      rst = 1'b1; en = 1'b1;
      req0 = 1'b1; req1 = 1'b1;
      data0 = 8'h11; data1 = 8'h22;
      model_n = 3;
      repeat (3) @(negedge clk);
      check_reset("reset");

      // Both requesters held from reset: 0x11, 0x22, 0x11, 0x22 back-to-back.
      rst = 1'b0;
      s = cyc + 1;
      s_last = s;
      for (int t = 0; t < 4; t++) begin
         s_last = s;
         push_txn(s, t[0], t[0] ? 8'h22 : 8'h11, 3);
         s = next_free + 1;
      end
      while (cyc < s_last) @(negedge clk);
      req0 = 1'b0;
      req1 = 1'b0;

      for (int i = 0; i < 10; i++) begin
         while (cyc < next_free) @(negedge clk);
         req0 = tbl[i].r0;
         req1 = tbl[i].r1;
         data0 = tbl[i].d0;
         data1 = tbl[i].d1;
         model_n = tbl[i].n;
         push_txn(cyc + 1, tbl[i].win, tbl[i].dat, tbl[i].n);
         @(negedge clk);
         if (tbl[i].win) req1 = 1'b0;
         else            req0 = 1'b0;
      end

      // en low blocks grants; raising it grants on the next cycle.
      while (cyc < next_free) @(negedge clk);
      en = 1'b0;
      req1 = 1'b1;
      data1 = 8'hC3;
      model_n = 10;
      g = 0;
      repeat (50) begin
         @(negedge clk);
         if (gnt0 | gnt1) g++;
      end
      check("no_grant_while_en0", g, 0);
      en = 1'b1;
      s = cyc + 1;
      push_evt(1, s, 8'hC3);
      @(negedge clk);
      req1 = 1'b0;

      // Reset in WAIT_DONE: silent abort, later tx_done from uart_tx is stray.
      while (cyc < s + 5) @(negedge clk);
      check("busy_before_rst", busy, 1);
      rst = 1'b1;
      @(negedge clk);
      check_reset("midrst");
      rst = 1'b0;
      g = 0;
      repeat (12) begin
         @(negedge clk);
         if (done0 | done1 | err) g++;
      end
      check("no_end_after_rst", g, 0);
      check("scoreboard_empty", sb.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter: TO_W, default 20, width of the transaction watchdog counter.
REQ-002 Parameter: TIMEOUT, default 200000, cycles allowed from start_tx to tx_done; valid range 2..2^TO_W-1.
REQ-003 Port: clk  in  1  single system clock; all logic on its rising edge.
REQ-004 Port: rst  in  1  synchronous, active-high reset.
REQ-005 Port: en  in  1  arbitration enable; new grants only while high.
REQ-006 Port: req0  in  1  requester 0 byte request; held high until gnt0.
REQ-007 Port: data0  in  8  requester 0 byte; stable while req0 high.
REQ-008 Port: req1  in  1  requester 1 byte request; held high until gnt1.
REQ-009 Port: data1  in  8  requester 1 byte; stable while req1 high.
REQ-010 Port: gnt0, gnt1  out  1 each  one-cycle pulse, byte accepted from that requester.
REQ-011 Port: done0, done1  out  1 each  one-cycle pulse, that requester's byte fully transmitted.
REQ-012 Port: err  out  1  one-cycle pulse, watchdog abort.
REQ-013 Port: owner  out  1  index of the requester owning the current transaction.
REQ-014 Port: busy  out  1  high in any state other than IDLE.
REQ-015 Port: start_tx  out  1  one-cycle start strobe to uart_tx.
REQ-016 Port: data_out  out  8  registered byte to uart_tx data_in.
REQ-017 Port: tx_busy  in  1  from uart_tx.
REQ-018 Port: tx_done  in  1  completion pulse from uart_tx.

Function
REQ-019 FSM states: IDLE, START, WAIT_BUSY, WAIT_DONE; all outputs registered.
REQ-020 IDLE: if en=1 and (req0|req1), select winner, latch its data into data_out, set owner, go to START; otherwise stay.
REQ-021 Winner selection: round-robin; single requester wins outright; both requesting -> index != last_served.
REQ-022 last_served updates to the winner on each grant; it does not change on err.
REQ-023 START lasts exactly one cycle: start_tx=1 and gnt[owner]=1 in the same cycle; next state WAIT_BUSY.
REQ-024 Grant latency: req sampled high in IDLE cycle N -> gnt and start_tx high in cycle N+1.
REQ-025 WAIT_BUSY: tx_done=1 -> done path (REQ-027); else tx_busy=1 -> WAIT_DONE; else stay.
REQ-026 WAIT_DONE: stay until tx_done=1.
REQ-027 Done path: on the cycle tx_done is sampled, next cycle done[owner]=1 and state IDLE.
REQ-028 Back-to-back: tx_done in cycle M -> IDLE in M+1 -> earliest next start_tx in M+2.
REQ-029 req0/req1 ignored outside IDLE; a request raised mid-transaction waits and is not lost while held.
REQ-030 Watchdog: counter cleared in START and incremented each cycle in WAIT_BUSY/WAIT_DONE.
REQ-031 Timeout: counter reaching TIMEOUT-1 without tx_done -> next cycle err=1, no done pulse, state IDLE.
REQ-032 Simultaneous tx_done and timeout in the same cycle: tx_done wins; no err pulse.
REQ-033 Counter saturates and never wraps.
REQ-034 en=0 does not abort a transaction in progress; it only blocks the IDLE->START transition.
REQ-035 Stray tx_done in IDLE or START is ignored; no done pulse.
REQ-036 At most one of gnt0, gnt1, done0, done1, err is high in any cycle.

Reset
REQ-037 rst=1 at a clock edge forces IDLE, last_served=1, watchdog=0.
REQ-038 Reset values: start_tx, gnt0, gnt1, done0, done1, err, busy, owner = 0; data_out = 8'h00.
REQ-039 Reset mid-transaction aborts silently: no done or err pulse; uart_tx completes on its own.

Verification
REQ-040 Single request: req0=1, data0=8'hA5, en=1; uart_tx model busy 2 cycles later -> gnt0 and start_tx high in the same single cycle; data_out=8'hA5; done0 one cycle after tx_done.
REQ-041 Contention: req0 and req1 held high from reset, data0=8'h11, data1=8'h22 -> order 8'h11, 8'h22, 8'h11, ... alternating; gnt never overlaps.
REQ-042 Timeout: TIMEOUT=16; start_tx issued, tx_busy/tx_done never asserted -> err pulse exactly 16 cycles after START; no done; busy=0 next cycle.
REQ-043 Race: tx_done asserted on the final watchdog cycle -> done pulse, err stays 0.
REQ-044 Enable/reset: en=0 with req1=1 -> no grant for 50 cycles; en=1 -> gnt1 next cycle; rst pulse during WAIT_DONE -> all outputs reset values, no done1.
